program_loader: RTL and testbench
=================================

# program_loader

Host-side initiator for the CPU's load port. Receives a byte stream over a valid/ready handshake and parses it into framed commands. Drives `address`, `inst_data`, `write_instruction` and `write_data` to fill instruction or data memory. Holds the CPU in reset until a run command arrives.

## Interface
- `ADDR_W`, 10: memory word-address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, 32: word width; payload is DATA_W/8 bytes per word.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_byte`  in  8  stream byte.
- `in_valid`  in  1  `in_byte` valid.
- `in_ready`  out  1  loader accepts a byte when `in_valid & in_ready`.
- `address`  out  ADDR_W  write address to CPU load port.
- `inst_data`  out  DATA_W  write word to CPU load port.
- `write_instruction`  out  1  one-cycle write strobe, instruction memory.
- `write_data`  out  1  one-cycle write strobe, data memory.
- `cpu_rst`  out  1  active-high reset to CPU.
- `busy`  out  1  frame in progress (state != IDLE).
- `err`  out  1  one-cycle pulse on protocol error.

## Operation
- Frame format: CMD, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words, each big-endian (MSB first).
- Only ADDR[ADDR_W-1:0] is used. CNT is a 16-bit word count.
- CMD 0x01 = load instruction memory. CMD 0x02 = load data memory. CMD 0x03 = run, a single-byte frame.
- FSM states: IDLE → ADDR_HI → ADDR_LO → CNT_HI → CNT_LO → PAYLOAD → (CHECK, only with checksum) → IDLE.
- In IDLE:
  - 0x01 or 0x02: latch the target, set `cpu_rst`=1 on the same accepting edge, go to ADDR_HI.
  - 0x03: `cpu_rst`←0, stay IDLE.
  - Any other value: `err` pulses, stay IDLE, `cpu_rst` unchanged.
- CNT_LO with CNT=0: no writes; return to IDLE (or CHECK if the checksum feature is compiled in).
- PAYLOAD:
  - A byte counter (0..DATA_W/8-1) shifts bytes into the word register.
  - On the last byte of a word: register the word and the current address, pulse the strobe for the latched target, increment the address (wrap 2^ADDR_W-1 → 0), decrement the remaining count.
  - After the last word: go to IDLE (or CHECK).
- Only one strobe is ever high in a cycle; the strobe is never asserted outside a load frame.
- A second load frame after a run re-asserts `cpu_rst`; the memory contents written earlier are preserved.

## Timing
- Reset values:
  - `cpu_rst`=1; `in_ready`=0 while `rst` is low.
  - `address`=0, `inst_data`=0, both strobes 0, `busy`=0, `err`=0.
  - State IDLE; all counters 0.
- `in_ready`=1 in every state once reset is released; the loader never stalls. Back-to-back bytes are accepted every cycle.
- Write latency: the strobe is high in the cycle after the edge that accepts the word's last byte.
  - `address` and `inst_data` are stable during that strobe cycle and hold until the next write.
  - Consecutive words at full rate give a strobe every DATA_W/8 cycles.
- `cpu_rst` changes on the edge accepting CMD; no extra latency.
- `err` pulses the cycle after the offending byte is accepted.
- Reset asserted mid-frame: the frame is aborted immediately. All outputs return to their reset values; no partial word is written.
- `in_valid` low mid-frame: state and counters hold indefinitely; there is no timeout.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After the payload (or after CNT_LO when CNT=0), the loader enters CHECK and expects one byte equal to the XOR of all payload bytes (0x00 when CNT=0).
  - On mismatch, `err` pulses the cycle after the byte is accepted and `cpu_rst` is forced to 1. Writes already performed are not undone.
  - On match, no pulse. Both cases then go to IDLE.
- Not defined: no CHECK state; the frame ends after the last payload byte or at CNT_LO when CNT=0.

## Test plan
- Reset, then frame 01 00 05 00 01 DE AD BE EF → exactly one `write_instruction` pulse with `address`=5, `inst_data`=0xDEADBEEF; `write_data` stays 0; `cpu_rst`=1.
- Data load 02 03 FF 00 02 followed by 8 bytes (words 0x11111111, 0x22222222) → `write_data` pulses at `address` 0x3FF then 0x000 (wrap); strobes 4 cycles apart at full rate.
- Byte 03 after a load → `cpu_rst` falls on the accepting edge. A following 01 header → `cpu_rst`=1 again on its accepting edge.
- Byte 0x7A in IDLE → single-cycle `err`; `busy`=0; no strobes; `cpu_rst` unchanged.
- `rst` low after the 2nd payload byte of a word → no strobe; outputs at reset values. After release, 01 00 00 00 00 → no writes, `busy` returns to 0.
- With `LOADER_CHECKSUM_EN`: 01 00 00 00 01 01 02 03 04 then checksum 0x04 → one write, no `err`. The same frame with checksum 0x05 → write occurs, `err` pulses, `cpu_rst`=1.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: host-side initiator for the CPU load port.
// Parses a byte stream (valid/ready) into framed commands:
//   CMD, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT big-endian words.
//   CMD 0x01 loads instruction memory, 0x02 loads data memory, 0x03 runs.
// Holds the CPU in reset (cpu_rst) from any load command until a run command.
// Optional feature: define LOADER_CHECKSUM_EN to expect a trailing XOR
// checksum byte per frame; a mismatch pulses err and forces cpu_rst high.
// Assumes 9 <= ADDR_W <= 16 and DATA_W a multiple of 8, at least 16.

module program_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] inst_data,
    output logic              write_instruction,
    output logic              write_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              err
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_HI = 3'd1,
        S_ADDR_LO = 3'd2,
        S_CNT_HI  = 3'd3,
        S_CNT_LO  = 3'd4,
        S_PAYLOAD = 3'd5
`ifdef LOADER_CHECKSUM_EN
        , S_CHECK = 3'd6
`endif
    } state_e;

    // State entered once the last payload word (or an empty count) is taken.
`ifdef LOADER_CHECKSUM_EN
    localparam state_e S_END = S_CHECK;
`else
    localparam state_e S_END = S_IDLE;
`endif

    state_e              state_q, state_d;
    logic                is_data_q, is_data_d;
    logic [ADDR_W-9:0]   addr_hi_q, addr_hi_d;
    logic [7:0]          cnt_hi_q, cnt_hi_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-9:0]   shift_q, shift_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                wr_inst_q, wr_inst_d;
    logic                wr_data_q, wr_data_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                accept;
    logic [DATA_W-1:0]   word_next;

    // The loader never stalls: ready follows reset release directly.
    assign in_ready  = rst;
    assign accept    = in_valid & in_ready;
    assign word_next = {shift_q, in_byte};

    assign address           = address_q;
    assign inst_data         = data_q;
    assign write_instruction = wr_inst_q;
    assign write_data        = wr_data_q;
    assign cpu_rst           = cpu_rst_q;
    assign err               = err_q;
    assign busy              = (state_q != S_IDLE);

    // Next-state and output decode for each accepted byte.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        is_data_d = is_data_q;
        addr_hi_d = addr_hi_q;
        cnt_hi_d  = cnt_hi_q;
        waddr_d   = waddr_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        address_d = address_q;
        data_d    = data_q;
        cpu_rst_d = cpu_rst_q;
        wr_inst_d = 1'b0;
        wr_data_d = 1'b0;
        err_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    case (in_byte)
                        8'h01, 8'h02: begin
                            is_data_d = (in_byte == 8'h02);
                            cpu_rst_d = 1'b1;
                            state_d   = S_ADDR_HI;
`ifdef LOADER_CHECKSUM_EN
                            csum_d    = 8'h00;
`endif
                        end
                        8'h03:   cpu_rst_d = 1'b0;
                        default: err_d     = 1'b1;
                    endcase
                end
                S_ADDR_HI: begin
                    addr_hi_d = in_byte[ADDR_W-9:0];
                    state_d   = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    waddr_d = {addr_hi_q, in_byte};
                    state_d = S_CNT_HI;
                end
                S_CNT_HI: begin
                    cnt_hi_d = in_byte;
                    state_d  = S_CNT_LO;
                end
                S_CNT_LO: begin
                    cnt_d   = {cnt_hi_q, in_byte};
                    idx_d   = '0;
                    state_d = (cnt_d == 16'd0) ? S_END : S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    shift_d = word_next[DATA_W-9:0];
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_byte;
`endif
                    if (idx_q == IDX_W'(BYTES - 1)) begin
                        // Last byte of a word: publish it and advance.
                        idx_d     = '0;
                        data_d    = word_next;
                        address_d = waddr_q;
                        wr_inst_d = ~is_data_q;
                        wr_data_d = is_data_q;
                        waddr_d   = waddr_q + ADDR_W'(1);
                        cnt_d     = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = S_END;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (in_byte != csum_q) begin
                        err_d     = 1'b1;
                        cpu_rst_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            is_data_q <= 1'b0;
            addr_hi_q <= '0;
            cnt_hi_q  <= '0;
            waddr_q   <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            address_q <= '0;
            data_q    <= '0;
            wr_inst_q <= 1'b0;
            wr_data_q <= 1'b0;
            cpu_rst_q <= 1'b1;
            err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            is_data_q <= is_data_d;
            addr_hi_q <= addr_hi_d;
            cnt_hi_q  <= cnt_hi_d;
            waddr_q   <= waddr_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            address_q <= address_d;
            data_q    <= data_d;
            wr_inst_q <= wr_inst_d;
            wr_data_q <= wr_data_d;
            cpu_rst_q <= cpu_rst_d;
            err_q     <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: a driver issues framed commands (directed and
// random) and queues the expected writes / error pulses with the cycle they
// must appear in; an independent monitor pops and compares on every event.
// Honours LOADER_CHECKSUM_EN the same way the design does.

module tb_program_loader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        in_byte = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] inst_data;
    logic              write_instruction;
    logic              write_data;
    logic              cpu_rst;
    logic              busy;
    logic              err;

    program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_byte           (in_byte),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .address           (address),
        .inst_data         (inst_data),
        .write_instruction (write_instruction),
        .write_data        (write_data),
        .cpu_rst           (cpu_rst),
        .busy              (busy),
        .err               (err)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event kinds: 0 instruction write, 1 data write, 2 error pulse.
    typedef struct {
        int                kind;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        longint            cyc;
    } ev_t;

    ev_t               evq[$];
    logic [DATA_W-1:0] wq[$];
    logic              exp_busy = 1'b0;
    logic              exp_cpu_rst = 1'b1;
    int                checks = 0;
    int                errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one byte at the falling edge; it is taken on the next rising edge.
    task automatic send_byte(input logic [7:0] b, input logic busy_after, input logic rst_after,
                             input int kind, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ev_t ev;
        @(negedge clk);
        in_byte  = b;
        in_valid = 1'b1;
        if (kind >= 0) begin
            ev.kind = kind;
            ev.addr = a;
            ev.data = d;
            ev.cyc  = cyc + 1;
            evq.push_back(ev);
        end
        @(posedge clk);
        exp_busy    = busy_after;
        exp_cpu_rst = rst_after;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_byte  = 8'($urandom);
        end
    endtask

    // Send a load frame carrying the words in wq; expected writes land at
    // consecutive addresses modulo 2^ADDR_W.
    task automatic send_load(input logic is_data, input logic [15:0] a, input int gmax, input logic bad_sum);
        int                n;
        logic [15:0]       n16;
        logic [7:0]        cs;
        logic [7:0]        b;
        logic [DATA_W-1:0] word;
        logic [ADDR_W-1:0] ea;
        logic              last_byte;
        n   = wq.size();
        n16 = 16'(n);
        cs  = 8'h00;
        send_byte(is_data ? 8'h02 : 8'h01, 1'b1, 1'b1, -1, '0, '0);
        gap($urandom_range(0, gmax));
        send_byte(a[15:8], 1'b1, 1'b1, -1, '0, '0);
        gap($urandom_range(0, gmax));
        send_byte(a[7:0], 1'b1, 1'b1, -1, '0, '0);
        gap($urandom_range(0, gmax));
        send_byte(n16[15:8], 1'b1, 1'b1, -1, '0, '0);
        gap($urandom_range(0, gmax));
        send_byte(n16[7:0], (n != 0) || CS_EN, 1'b1, -1, '0, '0);
        for (int w = 0; w < n; w++) begin
            word = wq[w];
            ea   = a[ADDR_W-1:0] + ADDR_W'(w);
            for (int k = 0; k < DATA_W / 8; k++) begin
                b         = word[DATA_W-1-8*k -: 8];
                cs        = cs ^ b;
                last_byte = (k == DATA_W / 8 - 1);
                gap($urandom_range(0, gmax));
                send_byte(b, !(last_byte && w == n - 1) || CS_EN, 1'b1,
                          last_byte ? (is_data ? 1 : 0) : -1, ea, word);
            end
        end
        if (CS_EN) begin
            gap($urandom_range(0, gmax));
            send_byte(bad_sum ? (cs ^ 8'h01) : cs, 1'b0, 1'b1, bad_sum ? 2 : -1, '0, '0);
        end
        wq.delete();
    endtask

    task automatic send_run();
        send_byte(8'h03, 1'b0, 1'b0, -1, '0, '0);
    endtask

    task automatic send_bad(input logic [7:0] b);
        send_byte(b, 1'b0, exp_cpu_rst, 2, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_cpu_rst", 64'(cpu_rst), 1);
        check("rst_address", 64'(address), 0);
        check("rst_inst_data", 64'(inst_data), 0);
        check("rst_strobes", 64'({write_instruction, write_data}), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_err", 64'(err), 0);
        check("rst_pending_events", 64'(evq.size()), 0);
        evq.delete();
        exp_busy    = 1'b0;
        exp_cpu_rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic observe(input int kind);
        ev_t ev;
        if (evq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            ev = evq.pop_front();
            check("event_kind", 64'(kind), 64'(ev.kind));
            check("event_cycle", 64'(cyc), 64'(ev.cyc));
            if (kind < 2) begin
                check("write_address", 64'(address), 64'(ev.addr));
                check("write_data_word", 64'(inst_data), 64'(ev.data));
            end
        end
    endtask

    // Monitor: samples just after the falling edge, away from the active edge.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                check("in_ready", 64'(in_ready), 1);
                check("busy", 64'(busy), 64'(exp_busy));
                check("cpu_rst", 64'(cpu_rst), 64'(exp_cpu_rst));
                check("one_strobe", 64'(write_instruction & write_data), 0);
                while (evq.size() > 0 && evq[0].cyc < cyc) begin
                    ev = evq.pop_front();
                    check("missed_event_cycle", 64'(cyc), 64'(ev.cyc));
                end
                if (write_instruction) observe(0);
                if (write_data) observe(1);
                if (err) observe(2);
            end
        end
    end

    initial begin
        int                r;
        int                n;
        logic [7:0]        bad;
        logic [15:0]       a;
        do_reset();

        // Single instruction word.
        wq.push_back(32'hDEADBEEF);
        send_load(1'b0, 16'h0005, 0, 1'b0);
        gap(3);

        // Data words across the address wrap, full rate.
        wq.push_back(32'h11111111);
        wq.push_back(32'h22222222);
        send_load(1'b1, 16'h03FF, 0, 1'b0);
        gap(2);

        // Run, then a new load re-asserts cpu_rst, then run again.
        send_run();
        gap(2);
        wq.push_back(32'hCAFEF00D);
        send_load(1'b0, 16'h0100, 1, 1'b0);
        send_run();
        gap(1);

        // Illegal command bytes in IDLE.
        send_bad(8'h7A);
        gap(2);
        send_bad(8'h00);
        send_bad(8'hFF);
        gap(2);

        // Reset in the middle of a word, then an empty frame.
        send_byte(8'h01, 1'b1, 1'b1, -1, '0, '0);
        send_byte(8'h00, 1'b1, 1'b1, -1, '0, '0);
        send_byte(8'h05, 1'b1, 1'b1, -1, '0, '0);
        send_byte(8'h00, 1'b1, 1'b1, -1, '0, '0);
        send_byte(8'h01, 1'b1, 1'b1, -1, '0, '0);
        send_byte(8'hDE, 1'b1, 1'b1, -1, '0, '0);
        send_byte(8'hAD, 1'b1, 1'b1, -1, '0, '0);
        do_reset();
        send_load(1'b0, 16'h0000, 0, 1'b0);
        gap(3);

        // Checksum frames: good then bad.
        if (CS_EN) begin
            wq.push_back(32'h01020304);
            send_load(1'b0, 16'h0000, 0, 1'b0);
            gap(1);
            wq.push_back(32'h01020304);
            send_load(1'b0, 16'h0000, 0, 1'b1);
            gap(2);
        end

        // Random mix of frames with random idle gaps.
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 5 || (r == 9 && !CS_EN)) begin
                n = $urandom_range(0, 5);
                for (int w = 0; w < n; w++) wq.push_back($urandom);
                a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h03FC, 16'h03FF))
                                                : 16'($urandom);
                send_load(r[0], a, 2, 1'b0);
            end else if (r <= 7) begin
                send_run();
            end else if (r == 8) begin
                bad = 8'($urandom);
                while (bad >= 8'h01 && bad <= 8'h03) bad = 8'($urandom);
                send_bad(bad);
            end else begin
                n = $urandom_range(0, 3);
                for (int w = 0; w < n; w++) wq.push_back($urandom);
                send_load(1'b1, 16'($urandom), 1, 1'b1);
            end
            gap($urandom_range(0, 3));
        end

        gap(10);
        check("events_drained", 64'(evq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
